// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS main control.
// Holds the opcode constants decoded by the FSM and the 4-bit state
// encodings, which are also visible on the debug 'state' port.
package multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        ADDI_EX   = 4'd9,
        ADDI_WB   = 4'd10,
        JUMP      = 4'd11,
        HALT      = 4'd15
    } mcState_t;

    // States that wait on the memory handshake and are covered by the timeout.
    function automatic logic isMemState(mcState_t s);
        return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
    endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Memory wait timer.
// Counts consecutive cycles with 'waitEn' high. 'expired' is raised in the
// cycle the count reaches TIMEOUT, i.e. the TIMEOUT-th waiting cycle.
// Ports:
//   clock, reset - clock and asynchronous active-high reset
//   clear        - restart the count (owner changes state)
//   waitEn       - this cycle is spent waiting on memory
//   expired      - this waiting cycle is the TIMEOUT-th one
// TIMEOUT must be >= 1 and 2**CNT_WIDTH must exceed TIMEOUT.
module mem_wait_timer #(
    parameter int TIMEOUT   = 16,
    parameter int CNT_WIDTH = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic waitEn,
    output logic expired
);
    localparam logic [CNT_WIDTH-1:0] LAST_WAIT = CNT_WIDTH'(TIMEOUT - 1);

    logic [CNT_WIDTH-1:0] count;

    // An expiry always forces a state change, which clears the count, so it
    // never runs past LAST_WAIT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (waitEn) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

    assign expired = waitEn && (count == LAST_WAIT);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle main control FSM for the MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback, waits on a variable
// latency memory via mem_ready with a timeout into a sticky HALT, flags
// unknown opcodes and supports J.
// Ports:
//   clock, reset         - clock, asynchronous active-high reset
//   Op, Zero, mem_ready  - opcode, ALU zero flag, memory completion
//   PCEn .. PCSource     - datapath controls (PCEn uses Zero)
//   BranchNe             - inverts the branch condition for BNE
//   illegal_op           - DECODE saw an unknown opcode (this cycle only)
//   fault                - in HALT after a memory timeout
//   state                - current state encoding
//
// state     | meaning
// FETCH     | read instruction at PC, PC += 4 when memory is ready
// DECODE    | compute branch target, dispatch on Op
// MEM_ADDR  | compute load/store address
// MEM_READ  | load data from memory
// MEM_WB    | write loaded data to rt
// MEM_WRITE | store rt to memory
// EXEC_R    | R-type ALU operation
// R_WB      | write ALU result to rd
// BRANCH    | compare, conditionally load branch target
// ADDI_EX   | rs + immediate
// ADDI_WB   | write ALU result to rt
// JUMP      | load jump target
// HALT      | memory timeout, sticky until reset
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OP_WIDTH  = 6,
    parameter int TIMEOUT   = 16,
    parameter int CNT_WIDTH = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OP_WIDTH-1:0] Op,
    input  logic                Zero,
    input  logic                mem_ready,
    output logic                PCEn,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemToReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic [1:0]          PCSource,
    output logic                BranchNe,
    output logic                illegal_op,
    output logic                fault,
    output logic [3:0]          state
);
    mcState_t stateReg, stateNext;
    logic     isBneReg, isBneNext;
    logic     PCWrite, PCWriteCond;
    logic     timerClear, timerWait, timerExpired;

    function automatic logic opIs(logic [OP_WIDTH-1:0] op, logic [5:0] code);
        return op == OP_WIDTH'(code);
    endfunction

    // Op is only meaningful in DECODE, so BEQ/BNE is remembered for BRANCH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateReg <= FETCH;
            isBneReg <= 1'b0;
        end else begin
            stateReg <= stateNext;
            isBneReg <= isBneNext;
        end
    end

    assign timerWait  = isMemState(stateReg) && !mem_ready;
    assign timerClear = (stateNext != stateReg);

    mem_wait_timer #(
        .TIMEOUT   (TIMEOUT),
        .CNT_WIDTH (CNT_WIDTH)
    ) uWaitTimer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timerClear),
        .waitEn  (timerWait),
        .expired (timerExpired)
    );

    always_comb begin
        stateNext   = stateReg;
        isBneNext   = isBneReg;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        BranchNe    = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        illegal_op  = 1'b0;
        fault       = 1'b0;

        case (stateReg)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready)         stateNext = DECODE;
                else if (timerExpired) stateNext = HALT;
            end
            DECODE: begin
                ALUSrcB   = 2'b11;
                isBneNext = opIs(Op, OP_BNE);
                if (opIs(Op, OP_RTYPE))                         stateNext = EXEC_R;
                else if (opIs(Op, OP_LW) || opIs(Op, OP_SW))    stateNext = MEM_ADDR;
                else if (opIs(Op, OP_BEQ) || opIs(Op, OP_BNE))  stateNext = BRANCH;
                else if (opIs(Op, OP_ADDI))                     stateNext = ADDI_EX;
                else if (opIs(Op, OP_J))                        stateNext = JUMP;
                else begin
                    illegal_op = 1'b1;
                    stateNext  = FETCH;
                end
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                // A non-memory opcode here never issues an access.
                if (opIs(Op, OP_LW))      stateNext = MEM_READ;
                else if (opIs(Op, OP_SW)) stateNext = MEM_WRITE;
                else                      stateNext = FETCH;
            end
            MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready)         stateNext = MEM_WB;
                else if (timerExpired) stateNext = HALT;
            end
            MEM_WB: begin
                RegWrite  = 1'b1;
                MemToReg  = 1'b1;
                stateNext = FETCH;
            end
            MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready)         stateNext = FETCH;
                else if (timerExpired) stateNext = HALT;
            end
            EXEC_R: begin
                ALUSrcA   = 1'b1;
                ALUOp     = 2'b10;
                stateNext = R_WB;
            end
            R_WB: begin
                RegWrite  = 1'b1;
                RegDst    = 1'b1;
                stateNext = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BranchNe    = isBneReg;
                stateNext   = FETCH;
            end
            ADDI_EX: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                stateNext = ADDI_WB;
            end
            ADDI_WB: begin
                RegWrite  = 1'b1;
                stateNext = FETCH;
            end
            JUMP: begin
                PCWrite   = 1'b1;
                PCSource  = 2'b10;
                stateNext = FETCH;
            end
            HALT: begin
                fault = 1'b1;
            end
            default: begin
                stateNext = FETCH;
            end
        endcase
    end

    assign PCEn  = PCWrite | (PCWriteCond & (Zero ^ BranchNe));
    assign state = stateReg;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control. Instructions are expanded into
// per-cycle plans (state sequence from the instruction class and the chosen
// memory latencies); each driven cycle pushes its expected outputs, and a
// monitor on the falling edge pops and compares.
module tb_multicycle_control;
    localparam int TIMEOUT = 16;

    localparam logic [5:0] R_OP = 6'h00, J_OP = 6'h02, BEQ_OP = 6'h04, BNE_OP = 6'h05;
    localparam logic [5:0] ADDI_OP = 6'h08, LW_OP = 6'h23, SW_OP = 6'h2B;

    typedef struct packed {
        logic       PCEn, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA;
        logic [1:0] ALUSrcB, ALUOp, PCSource;
        logic       BranchNe, illegal_op, fault;
        logic [3:0] state;
    } outs_t;

    logic       clock, reset, Zero, mem_ready;
    logic [5:0] Op;
    logic       PCEn, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       BranchNe, illegal_op, fault;
    logic [3:0] state;

    outs_t expQ[$];
    string tagQ[$];
    int    checks = 0;
    int    errors = 0;

    multicycle_control #(.OP_WIDTH(6), .TIMEOUT(TIMEOUT), .CNT_WIDTH(5)) dut (
        .clock(clock), .reset(reset), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
        .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .BranchNe(BranchNe), .illegal_op(illegal_op), .fault(fault), .state(state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic isLegal(logic [5:0] op);
        return op inside {R_OP, J_OP, BEQ_OP, BNE_OP, ADDI_OP, LW_OP, SW_OP};
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // Expected control word for a cycle spent in state st while executing iop.
    function automatic outs_t expectFor(int st, logic [5:0] iop, logic zr, logic rdy);
        outs_t o;
        o = '0;
        o.state = 4'(st);
        case (st)
            0:  begin o.MemRead = 1; o.ALUSrcB = 2'b01; o.IRWrite = rdy; o.PCEn = rdy; end
            1:  begin o.ALUSrcB = 2'b11; o.illegal_op = !isLegal(iop); end
            2:  begin o.ALUSrcA = 1; o.ALUSrcB = 2'b10; end
            3:  begin o.MemRead = 1; o.IorD = 1; end
            4:  begin o.RegWrite = 1; o.MemToReg = 1; end
            5:  begin o.MemWrite = 1; o.IorD = 1; end
            6:  begin o.ALUSrcA = 1; o.ALUOp = 2'b10; end
            7:  begin o.RegWrite = 1; o.RegDst = 1; end
            8:  begin
                    o.ALUSrcA = 1; o.ALUOp = 2'b01; o.PCSource = 2'b01;
                    o.BranchNe = (iop == BNE_OP);
                    // BEQ takes the branch on Zero, BNE on !Zero
                    o.PCEn = (iop == BNE_OP) ? !zr : zr;
                end
            9:  begin o.ALUSrcA = 1; o.ALUSrcB = 2'b10; end
            10: begin o.RegWrite = 1; end
            11: begin o.PCEn = 1; o.PCSource = 2'b10; end
            15: begin o.fault = 1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic step(input int st, input logic [5:0] iop, input logic [5:0] opIn,
                        input logic rdy, input logic zr, input logic rst, input string tag);
        @(posedge clock);
        #1;
        reset     = rst;
        Op        = opIn;
        Zero      = zr;
        mem_ready = rdy;
        expQ.push_back(expectFor(st, iop, zr, rdy));
        tagQ.push_back(tag);
    endtask

    // Cycle where Op, Zero and mem_ready should not matter.
    task automatic busy(input int st, input logic [5:0] iop, input string tag);
        step(st, iop, rop(), rb(), rb(), 1'b0, tag);
    endtask

    // Cycle where Op is sampled and must hold the instruction opcode.
    task automatic held(input int st, input logic [5:0] iop, input string tag);
        step(st, iop, iop, rb(), rb(), 1'b0, tag);
    endtask

    task automatic doReset(input int n);
        repeat (n) step(0, 6'h00, rop(), 1'b0, rb(), 1'b1, "reset");
    endtask

    // n waiting cycles, then ready; n >= TIMEOUT ends in HALT and a reset.
    task automatic memWait(input int st, input logic [5:0] iop, input int n,
                           input string tag, output bit halted);
        halted = 0;
        for (int i = 0; i < n && i < TIMEOUT; i++)
            step(st, iop, rop(), 1'b0, rb(), 1'b0, tag);
        if (n >= TIMEOUT) begin
            halted = 1;
            repeat (3) busy(15, iop, "halt");
            doReset(2);
        end else begin
            step(st, iop, rop(), 1'b1, rb(), 1'b0, tag);
        end
    endtask

    task automatic runInstr(input logic [5:0] iop, input int wFetch, input int wMem, input logic zr);
        bit h;
        memWait(0, iop, wFetch, "fetch", h);
        if (h) return;
        held(1, iop, "decode");
        if (!isLegal(iop)) return;
        case (iop)
            R_OP:    begin busy(6, iop, "exec_r"); busy(7, iop, "r_wb"); end
            LW_OP:   begin
                         held(2, iop, "mem_addr");
                         memWait(3, iop, wMem, "mem_read", h);
                         if (!h) busy(4, iop, "mem_wb");
                     end
            SW_OP:   begin held(2, iop, "mem_addr"); memWait(5, iop, wMem, "mem_write", h); end
            BEQ_OP, BNE_OP: step(8, iop, rop(), rb(), zr, 1'b0, "branch");
            ADDI_OP: begin busy(9, iop, "addi_ex"); busy(10, iop, "addi_wb"); end
            J_OP:    busy(11, iop, "jump");
            default: ;
        endcase
    endtask

    always @(negedge clock) begin
        outs_t e, g;
        string t;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            t = tagQ.pop_front();
            g = '{PCEn, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA,
                  ALUSrcB, ALUOp, PCSource, BranchNe, illegal_op, fault, state};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s t=%0t got=%h (state %0d) expected=%h (state %0d)",
                         t, $time, g, g.state, e, e.state);
            end
        end
    end

    initial begin
        logic [5:0] legalOps [7];
        logic [5:0] op;
        int         r, wF, wM;
        bit         h;
        legalOps = '{R_OP, J_OP, BEQ_OP, BNE_OP, ADDI_OP, LW_OP, SW_OP};

        reset = 1'b1; Op = '0; Zero = 1'b0; mem_ready = 1'b0;
        doReset(2);

        runInstr(R_OP, 0, 0, 1'b0);
        runInstr(LW_OP, 0, 2, 1'b0);
        runInstr(BNE_OP, 0, 0, 1'b0);
        runInstr(BNE_OP, 0, 0, 1'b1);
        runInstr(BEQ_OP, 0, 0, 1'b0);
        runInstr(BEQ_OP, 0, 0, 1'b1);
        runInstr(6'h3F, 0, 0, 1'b0);
        runInstr(J_OP, 1, 0, 1'b0);
        runInstr(ADDI_OP, 0, 0, 1'b0);
        runInstr(SW_OP, 0, TIMEOUT, 1'b0);
        runInstr(SW_OP, 0, TIMEOUT - 1, 1'b0);
        runInstr(LW_OP, TIMEOUT, 0, 1'b0);

        // Reset while stalled in MEM_WRITE, then prove the wait count restarted.
        memWait(0, SW_OP, 0, "fetch", h);
        held(1, SW_OP, "decode");
        held(2, SW_OP, "mem_addr");
        repeat (5) step(5, SW_OP, rop(), 1'b0, rb(), 1'b0, "mem_write");
        doReset(2);
        runInstr(SW_OP, 0, TIMEOUT - 1, 1'b0);
        runInstr(R_OP, 0, 0, 1'b0);

        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                do op = rop(); while (isLegal(op));
            end else begin
                op = legalOps[$urandom_range(0, 6)];
            end
            wF = ($urandom_range(0, 24) == 0) ? TIMEOUT : $urandom_range(0, 3);
            r  = $urandom_range(0, 15);
            wM = (r == 0) ? TIMEOUT : (r == 1) ? TIMEOUT - 1 : $urandom_range(0, 4);
            runInstr(op, wF, wM, rb());
        end

        repeat (3) @(posedge clock);
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle main control FSM for the MIPS datapath. It replaces the single-cycle opcode decoder.
- It sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK per instruction.
- It handshakes with a variable-latency memory through `mem_ready`, with a parametrised timeout.
- It adds jump support, illegal-opcode flagging and a sticky fault halt.

Parameters:
- `OP_WIDTH`, 6, opcode field width.
- `TIMEOUT`, 16, maximum cycles to wait for `mem_ready` in any memory state before fault; must be ≥ 1.
- `CNT_WIDTH`, 5, wait-counter width; must satisfy 2^`CNT_WIDTH` > `TIMEOUT`.

Ports:
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `Op`  in  `OP_WIDTH`  opcode from the instruction register
- `Zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory has completed the current read/write this cycle
- `PCEn`  out  1  PC load enable = `PCWrite` | (`PCWriteCond` & (`Zero` ^ `BranchNe`))
- `IorD`  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- `MemRead`  out  1  memory read request
- `MemWrite`  out  1  memory write request
- `IRWrite`  out  1  instruction register load
- `MemToReg`  out  1  register write data select: 1 = MDR
- `RegDst`  out  1  1 = rd, 0 = rt
- `RegWrite`  out  1  register file write
- `ALUSrcA`  out  1  0 = PC, 1 = rs
- `ALUSrcB`  out  2  00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- `ALUOp`  out  2  00 = add, 01 = subtract, 10 = funct-decoded
- `PCSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `BranchNe`  out  1  inverts the branch condition (BNE)
- `illegal_op`  out  1  one-cycle pulse when DECODE sees an unknown opcode
- `fault`  out  1  sticky memory timeout flag; FSM is in HALT
- `state`  out  4  current state encoding, for debug and bench

Behaviour:

General rules:
- All control outputs are Moore (decoded from `state`), except:
  - `PCEn`, which uses `Zero`.
  - FETCH `IRWrite`/`PCWrite`, which are gated by `mem_ready`.
- Every output not listed for a state is 0.

Reset:
- On `reset`=1, asynchronously: state=FETCH, wait counter=0, `fault`=0, `illegal_op`=0.
- Outputs then equal the FETCH decode.
- A reset asserted mid-instruction abandons that instruction. No partial write may be issued after `reset` deasserts.

States and outputs:
- FETCH: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCSource`=00. `IRWrite`=`PCWrite`=`mem_ready`. Goes to DECODE when `mem_ready`=1, else holds.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=00 (computes branch target). Next state by `Op`:
  - R_TYPE→EXEC_R
  - LW/SW→MEM_ADDR
  - BEQ/BNE→BRANCH
  - ADDI→ADDI_EX
  - J→JUMP
  - other→FETCH, with `illegal_op`=1 for this cycle only.
- MEM_ADDR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. LW→MEM_READ, SW→MEM_WRITE.
- MEM_READ: `MemRead`=1, `IorD`=1. Goes to MEM_WB on `mem_ready`, else holds.
- MEM_WB: `RegWrite`=1, `MemToReg`=1, `RegDst`=0. Then FETCH.
- MEM_WRITE: `MemWrite`=1, `IorD`=1. Goes to FETCH on `mem_ready`, else holds.
- EXEC_R: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10. Then R_WB.
- R_WB: `RegWrite`=1, `RegDst`=1, `MemToReg`=0. Then FETCH.
- ADDI_EX: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. Then ADDI_WB.
- ADDI_WB: `RegWrite`=1, `RegDst`=0, `MemToReg`=0. Then FETCH.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCWriteCond`=1, `PCSource`=01. `BranchNe`=1 only for BNE. Then FETCH.
- JUMP: `PCWrite`=1, `PCSource`=10. Then FETCH.
- HALT: all enables 0, `fault`=1. Exits only on `reset`.

Latency:
- With `mem_ready` held at 1, instruction latency in cycles is: LW 5; SW, R-type and ADDI 4; BEQ, BNE and J 3.

Wait counter:
- Clears on every state change.
- Increments each cycle spent in FETCH, MEM_READ or MEM_WRITE with `mem_ready`=0.
- When the count reaches `TIMEOUT` with `mem_ready` still 0, the next state is HALT.
- `mem_ready`=1 on the same cycle the count reaches `TIMEOUT` wins: normal transition.
- `Op` is sampled only in DECODE and MEM_ADDR. `Op` changes in other states have no effect.

Decomposition:
- Opcode constants live in the shared `opcodes.v`; add J (2) there.
- New shared header `mc_states.v` holds the 4-bit state encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, R_WB=7, BRANCH=8, ADDI_EX=9, ADDI_WB=10, JUMP=11, HALT=15.
- Natural sub-module: `mem_wait_timer`, parametrised by `TIMEOUT`/`CNT_WIDTH`, with inputs clear and wait and output expired.

Test Plan:
- R-type: `mem_ready`=1, `Op`=0 → states 0,1,6,7,0. `RegWrite`=1 and `RegDst`=1 only in state 7.
- LW with memory latency: `Op`=0x23, `mem_ready` low for 2 cycles in MEM_READ → 7 cycles total. `MemRead`=`IorD`=1 throughout MEM_READ. MEM_WB `MemToReg`=1.
- BNE: `Op`=5, `Zero`=0 → `PCEn`=1 in BRANCH with `PCSource`=01. Repeat with `Zero`=1 → `PCEn`=0. BEQ (`Op`=4) gives the opposite results.
- Illegal opcode: `Op`=0x3F → `illegal_op` high exactly 1 cycle in DECODE, then FETCH. No `RegWrite`/`MemWrite` is ever asserted.
- Timeout: SW (`Op`=0x2B) with `mem_ready`=0 for `TIMEOUT`(16) cycles in MEM_WRITE → state=15, `fault`=1, held. A second run with `mem_ready`=1 on the 16th cycle → FETCH, no fault.
- Reset mid-instruction: assert `reset` in MEM_WRITE → `MemWrite` drops asynchronously, state=0, `fault` cleared, normal fetch resumes after release.
